// File: rtl/exc_sched.sv
// Exception request scheduler: latches request pulses, picks one by fixed priority and runs
// the Exc/ExcAck handshake, then blocks further exceptions until ERet.
module exc_sched #(
  parameter int unsigned NSRC        = 4,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_req,
  input  logic [NSRC-1:0] irq_mask,
  input  logic            ExcAck,
  input  logic            ERet,
  input  logic            ovr_clr,
  output logic            Exc,
  output logic [3:0]      EStatus,
  output logic            in_handler,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] overrun,
  output logic            ack_timeout
);

  localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CntW-1:0] TermCnt = CntW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StHandler} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] sel_onehot;
  logic [NSRC-1:0] new_ovr;
  logic [3:0]      sel_idx;
  logic            take;

  // Descending scan so the lowest eligible index is the one left in sel_idx.
  always_comb begin
    eligible = pending & ~irq_mask;
    sel_idx  = 4'd0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (eligible[i]) sel_idx = 4'(i);
    end
    take       = (state_q == StIdle) && (|eligible);
    sel_onehot = take ? (NSRC'(1) << sel_idx) : '0;
    new_ovr    = irq_req & pending & ~sel_onehot;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      Exc         <= 1'b0;
      EStatus     <= 4'd0;
      in_handler  <= 1'b0;
      pending     <= '0;
      overrun     <= '0;
      ack_timeout <= 1'b0;
    end else begin
      // A same-cycle request re-sets a bit being cleared by selection.
      pending     <= (pending & ~sel_onehot) | irq_req;
      overrun     <= (ovr_clr ? '0 : overrun) | new_ovr;
      ack_timeout <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (take) begin
            EStatus <= sel_idx + 4'd1;
            Exc     <= 1'b1;
            cnt_q   <= '0;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (ExcAck) begin
            Exc        <= 1'b0;
            in_handler <= 1'b1;
            state_q    <= StHandler;
          end else if (cnt_q == TermCnt) begin
            Exc         <= 1'b0;
            ack_timeout <= 1'b1;
            state_q     <= StIdle;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StHandler: begin
          if (ERet) begin
            in_handler <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_sched.sv
// Directed bench for exc_sched: cycle-level behavioural model compared every cycle,
// plus hand-computed expectations along the directed scenarios.
module tb_exc_sched;
  localparam int NSRC = 4;
  localparam int ACK_TIMEOUT = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [NSRC-1:0] irq_req = '0;
  logic [NSRC-1:0] irq_mask = '0;
  logic            ExcAck = 1'b0;
  logic            ERet = 1'b0;
  logic            ovr_clr = 1'b0;
  logic            Exc;
  logic [3:0]      EStatus;
  logic            in_handler;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] overrun;
  logic            ack_timeout;

  int n_checks = 0;
  int n_err = 0;

  exc_sched #(.NSRC(NSRC), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .irq_req(irq_req), .irq_mask(irq_mask), .ExcAck(ExcAck),
    .ERet(ERet), .ovr_clr(ovr_clr), .Exc(Exc), .EStatus(EStatus), .in_handler(in_handler),
    .pending(pending), .overrun(overrun), .ack_timeout(ack_timeout)
  );

  always #5 clk = ~clk;

  function void chk(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  // Behavioural model: mode 0 idle, 1 requesting, 2 in handler; m_age = cycles Exc has been up.
  bit m_pend[NSRC];
  bit m_ovr[NSRC];
  int m_mode = 0;
  int m_code = 0;
  int m_age = 0;
  bit m_tpulse = 1'b0;

  function automatic logic [NSRC-1:0] pack(bit a[NSRC]);
    logic [NSRC-1:0] v;
    for (int i = 0; i < NSRC; i++) v[i] = a[i];
    return v;
  endfunction

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      for (int i = 0; i < NSRC; i++) begin
        m_pend[i] = 1'b0;
        m_ovr[i] = 1'b0;
      end
      m_mode = 0;
      m_code = 0;
      m_age = 0;
      m_tpulse = 1'b0;
    end else begin
      int took;
      took = -1;
      if (m_mode == 0)
        for (int i = 0; i < NSRC; i++)
          if (took < 0 && m_pend[i] && !irq_mask[i]) took = i;
      for (int i = 0; i < NSRC; i++) begin
        if (irq_req[i] && m_pend[i] && i != took) m_ovr[i] = 1'b1;
        else if (ovr_clr) m_ovr[i] = 1'b0;
        if (irq_req[i]) m_pend[i] = 1'b1;
        else if (i == took) m_pend[i] = 1'b0;
      end
      m_tpulse = 1'b0;
      case (m_mode)
        0: if (took >= 0) begin
          m_mode = 1;
          m_code = took + 1;
          m_age = 1;
        end
        1: if (ExcAck) m_mode = 2;
           else if (m_age == ACK_TIMEOUT) begin
             m_mode = 0;
             m_tpulse = 1'b1;
           end else m_age++;
        default: if (ERet) m_mode = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("model_exc", 32'(Exc), 32'(m_mode == 1));
    chk("model_in_handler", 32'(in_handler), 32'(m_mode == 2));
    chk("model_estatus", 32'(EStatus), 32'(m_code));
    chk("model_pending", 32'(pending), 32'(pack(m_pend)));
    chk("model_overrun", 32'(overrun), 32'(pack(m_ovr)));
    chk("model_ack_timeout", 32'(ack_timeout), 32'(m_tpulse));
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_req(logic [NSRC-1:0] v);
    irq_req = v;
    cyc(1);
    irq_req = '0;
  endtask

  task automatic wait_exc();
    int k;
    k = 0;
    while (Exc !== 1'b1 && k < 40) begin
      cyc(1);
      k++;
    end
    chk("exc_seen", 32'(Exc), 32'd1);
  endtask

  task automatic ack_it();
    ExcAck = 1'b1;
    cyc(1);
    ExcAck = 1'b0;
    chk("ack_exc_low", 32'(Exc), 32'd0);
    chk("ack_in_handler", 32'(in_handler), 32'd1);
  endtask

  task automatic eret_it();
    ERet = 1'b1;
    cyc(1);
    ERet = 1'b0;
    chk("eret_in_handler", 32'(in_handler), 32'd0);
  endtask

  task automatic serve(int code);
    wait_exc();
    chk("serve_estatus", 32'(EStatus), 32'(code));
    ack_it();
    eret_it();
  endtask

  initial begin
    int n;
    cyc(2);
    chk("rst_exc", 32'(Exc), 32'd0);
    chk("rst_estatus", 32'(EStatus), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    reset = 1'b1;
    cyc(1);

    // Single request
    pulse_req(4'b0010);
    chk("t1_pending", 32'(pending), 32'b0010);
    chk("t1_exc_not_yet", 32'(Exc), 32'd0);
    cyc(1);
    chk("t1_exc", 32'(Exc), 32'd1);
    chk("t1_estatus", 32'(EStatus), 32'd2);
    chk("t1_pending_clr", 32'(pending), 32'd0);
    cyc(2);
    ack_it();
    eret_it();

    // Priority and mask
    irq_mask = 4'b0001;
    pulse_req(4'b1101);
    chk("t2_pending", 32'(pending), 32'b1101);
    serve(3);
    serve(4);
    chk("t2_masked_pending", 32'(pending), 32'b0001);
    cyc(2);
    chk("t2_masked_no_exc", 32'(Exc), 32'd0);
    irq_mask = 4'b0000;
    serve(1);

    // Overrun
    pulse_req(4'b0010);
    wait_exc();
    ack_it();
    pulse_req(4'b0100);
    pulse_req(4'b0100);
    chk("t3_overrun", 32'(overrun), 32'b0100);
    chk("t3_pending", 32'(pending), 32'b0100);
    ovr_clr = 1'b1;
    cyc(1);
    ovr_clr = 1'b0;
    chk("t3_ovr_clr", 32'(overrun), 32'd0);
    irq_req = 4'b0100;
    ovr_clr = 1'b1;
    cyc(1);
    irq_req = '0;
    ovr_clr = 1'b0;
    chk("t3_ovr_beats_clr", 32'(overrun), 32'b0100);
    ovr_clr = 1'b1;
    cyc(1);
    ovr_clr = 1'b0;
    eret_it();
    serve(3);

    // Set wins over clear
    pulse_req(4'b0001);
    pulse_req(4'b0001);
    chk("t4_exc", 32'(Exc), 32'd1);
    chk("t4_estatus", 32'(EStatus), 32'd1);
    chk("t4_pending_kept", 32'(pending), 32'b0001);
    chk("t4_no_overrun", 32'(overrun), 32'd0);
    ack_it();
    eret_it();
    serve(1);

    // Timeout
    pulse_req(4'b1000);
    wait_exc();
    n = 0;
    while (Exc === 1'b1 && n < 40) begin
      n++;
      cyc(1);
    end
    chk("t5_exc_cycles", 32'(n), 32'd16);
    chk("t5_ack_timeout", 32'(ack_timeout), 32'd1);
    chk("t5_in_handler", 32'(in_handler), 32'd0);
    cyc(1);
    chk("t5_pulse_one_cycle", 32'(ack_timeout), 32'd0);
    pulse_req(4'b1000);
    wait_exc();
    cyc(15);
    chk("t5b_exc_still", 32'(Exc), 32'd1);
    ack_it();
    chk("t5b_no_timeout", 32'(ack_timeout), 32'd0);
    cyc(1);
    chk("t5b_no_timeout_late", 32'(ack_timeout), 32'd0);
    eret_it();

    // Async reset mid-REQ and mid-handler
    pulse_req(4'b0110);
    wait_exc();
    #2 reset = 1'b0;
    #1;
    chk("t6_exc", 32'(Exc), 32'd0);
    chk("t6_estatus", 32'(EStatus), 32'd0);
    chk("t6_pending", 32'(pending), 32'd0);
    chk("t6_in_handler", 32'(in_handler), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    ExcAck = 1'b1;
    ERet = 1'b1;
    cyc(1);
    ExcAck = 1'b0;
    ERet = 1'b0;
    chk("t6_ack_ignored", 32'(in_handler), 32'd0);
    chk("t6_exc_idle", 32'(Exc), 32'd0);
    pulse_req(4'b0001);
    wait_exc();
    ack_it();
    #2 reset = 1'b0;
    #1;
    chk("t6_handler_drop", 32'(in_handler), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/exc_sched.md
# exc_sched

Exception request scheduler for the pipelined ARM core. It collects single-cycle exception requests from several sources and holds them as pending. It selects one by fixed priority, drives `Exc` and the 4-bit `EStatus` code into the exception unit, and completes the `Exc`/`ExcAck` handshake. It then blocks further exceptions until the handler executes `ERet`, so the exception unit (ELR/ERR/ESR capture, vector fetch, return branch) serves one exception at a time.

## Interface
Parameters:
- `NSRC`, default 4: number of request sources, 1..15.
- `ACK_TIMEOUT`, default 16: maximum cycles `Exc` stays high without `ExcAck`; must be ≥ 2.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low (0 = in reset).
- `irq_req`, input, NSRC: single-cycle request pulse per source; bit 0 has the highest priority.
- `irq_mask`, input, NSRC: 1 = source not eligible for selection; its pending bit is kept.
- `ExcAck`, input, 1: exception unit is fetching the exception vector.
- `ERet`, input, 1: return-from-exception instruction executing.
- `ovr_clr`, input, 1: clears all `overrun` bits.
- `Exc`, output, 1: exception request to the exception unit (registered).
- `EStatus`, output, 4: code of the selected source, equal to index+1; 0 means none.
- `in_handler`, output, 1: high from ack until `ERet`.
- `pending`, output, NSRC: latched, not-yet-taken requests.
- `overrun`, output, NSRC: sticky flag; a request arrived while the same source was already pending.
- `ack_timeout`, output, 1: one-cycle pulse when the handshake is abandoned.

## Operation
- Reset values (reset=0, applied asynchronously): state IDLE; `Exc`=0, `EStatus`=0, `in_handler`=0, `pending`=0, `overrun`=0, `ack_timeout`=0; timeout counter 0.
- Pending bits:
  - `irq_req[i]`=1 at an edge sets `pending[i]`.
  - Selection of source i clears `pending[i]`.
  - Set wins over clear in the same cycle: `pending[i]` stays 1 and no overrun is flagged.
- Overrun:
  - `irq_req[i]`=1 while `pending[i]`=1, and i is not being selected that cycle, sets `overrun[i]`.
  - `ovr_clr` clears all overrun bits. If a new overrun occurs in the same cycle as `ovr_clr`, that bit is set.
- Eligible set = `pending & ~irq_mask`. Selection takes the lowest eligible index.
- States:
  - IDLE:
    - If the eligible set is non-empty, select source i at this edge: clear `pending[i]`, set `EStatus`←i+1, `Exc`←1, counter←0, go to REQ.
    - Otherwise stay in IDLE.
  - REQ (`Exc`=1):
    - If `ExcAck`=1: `Exc`←0, `in_handler`←1, go to HANDLER.
    - Else if counter == ACK_TIMEOUT−1: `Exc`←0, `ack_timeout`←1 for one cycle, go to IDLE. The dropped source is not re-pended.
    - Else counter+1.
  - HANDLER: on `ERet`=1, `in_handler`←0 and go to IDLE. There is no nesting; new requests only accumulate in `pending`.
- `EStatus` holds the last selected code until the next selection; it does not return to 0 outside reset.
- Ignored inputs: `ExcAck` in IDLE or HANDLER; `ERet` in IDLE or REQ.
- Masking a source after it has been selected has no effect on the exception in flight.
- Counter width is clog2(ACK_TIMEOUT+1). The counter saturates; it never wraps.

## Timing
- Request to `Exc`: a pulse at edge k sets `pending` after k. If the source is eligible and the state is IDLE, `Exc`=1 and `EStatus` are valid after edge k+1 (2-cycle latency).
- `Exc` deasserts on the edge that samples `ExcAck`=1. `in_handler` rises on the same edge.
- Without an ack, `Exc` is high for exactly ACK_TIMEOUT cycles. `ack_timeout` pulses in the cycle after `Exc` falls.
- If `ExcAck` arrives in the terminal-count cycle, the ack wins: no timeout.
- Re-arm: after the `ERet` edge the state is IDLE. The next eligible selection occurs at the following edge, so there is a minimum of 1 idle cycle between exceptions.
- Reset asserted mid-handshake or mid-handler drops `Exc` and `in_handler` immediately and discards all pending requests.

## Test plan
- Single request: `irq_req`=0010 for one cycle → `pending`=0010. Next edge: `Exc`=1, `EStatus`=2, `pending`=0000. `ExcAck` 3 cycles later → `Exc`=0, `in_handler`=1. `ERet` → `in_handler`=0, IDLE.
- Priority and mask: `irq_req`=1101 with `irq_mask`=0001 → first `EStatus`=3. After `ERet`, next `EStatus`=4. Bit 0 stays pending until the mask is cleared, then `EStatus`=1.
- Overrun: pulse `irq_req[2]` twice while `in_handler`=1 → `overrun`=0100 and `pending[2]`=1 (one entry only). `ovr_clr` → `overrun`=0000.
- Set-wins-clear: `irq_req[0]` pulses on the exact edge source 0 is selected → `pending[0]` remains 1, `overrun[0]`=0. It is served again after `ERet`.
- Timeout: with ACK_TIMEOUT=16 and no `ExcAck` → `Exc` high 16 cycles, `ack_timeout` one-cycle pulse, state IDLE, `in_handler`=0. Variant: ack on cycle 16 → no timeout, HANDLER.
- Async reset: drop `reset` mid-REQ, between clock edges → `Exc`, `EStatus`, `pending`, `in_handler` go to 0 without waiting for an edge. `ERet` or `ExcAck` issued after reset release is ignored.
